// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC, 2-entry fetch buffer toward decode,
// redirect handling and halt-on-illegal-PC fault state.
module instruction_fetch_unit #(
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC     = 32'h0040_0000,
    parameter int                      MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  fault
);

    typedef enum logic {S_RUN, S_FAULT} state_t;

    // One extra bit so the upper bound cannot wrap at the top of the address space
    localparam logic [DATA_WIDTH:0] PC_LO = {1'b0, RESET_PC};
    localparam logic [DATA_WIDTH:0] PC_HI = PC_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    state_t                          r_state;
    logic                            r_fault;
    logic [DATA_WIDTH-1:0]           r_pc;
    logic [1:0]                      r_count;
    logic [1:0][DATA_WIDTH-1:0]      r_q_pc;
    logic [1:0][DATA_WIDTH-1:0]      r_q_ins;

    logic                            w_legal;
    logic                            w_pop;
    logic                            w_fetch;

    assign w_legal = (r_pc[1:0] == 2'b00) && ({1'b0, r_pc} >= PC_LO) && ({1'b0, r_pc} < PC_HI);
    assign w_pop   = out_valid && out_ready;
    assign w_fetch = (r_state == S_RUN) && !redirect_valid && w_legal
                     && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_count <= 2'd0;
            r_state <= S_RUN;
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_count <= 2'd0;
            r_state <= S_RUN;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!w_legal) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase

            if (w_fetch)
                r_pc <= r_pc + DATA_WIDTH'(4);

            // Entry 0 is always the head; a pop shifts entry 1 forward
            case ({w_pop, w_fetch})
                2'b01: begin
                    r_q_pc[r_count[0]]  <= r_pc;
                    r_q_ins[r_count[0]] <= mem_instruction;
                    r_count             <= r_count + 2'd1;
                end
                2'b10: begin
                    r_q_pc[0]  <= r_q_pc[1];
                    r_q_ins[0] <= r_q_ins[1];
                    r_count    <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_pc[0]  <= r_pc;
                        r_q_ins[0] <= mem_instruction;
                    end else begin
                        r_q_pc[0]  <= r_q_pc[1];
                        r_q_ins[0] <= r_q_ins[1];
                        r_q_pc[1]  <= r_pc;
                        r_q_ins[1] <= mem_instruction;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_address     = r_pc;
    assign out_valid       = (r_count != 2'd0);
    assign out_pc          = out_valid ? r_q_pc[0]  : '0;
    assign out_instruction = out_valid ? r_q_ins[0] : '0;
    assign fault           = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: scoreboard of accepted fetches
// plus direct checks of reset, stall, redirect and fault behaviour.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_address, mem_instruction, out_instruction, out_pc;
    logic        out_valid, fault;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;
    item_t sb[$];

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    // Program memory: word i holds 11*(i+1)
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a >= BASE && a < BASE + 32'd128)
            return 32'd11 * (((a - BASE) >> 2) + 32'd1);
        return 32'hBAD0_0BAD;
    endfunction
    assign mem_instruction = rom(mem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_item(input int idx);
        item_t it;
        it.pc  = BASE + 32'(4 * idx);
        it.ins = 32'(11 * (idx + 1));
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an item is accepted when the next edge pops it without flush
    initial begin
        forever begin
            item_t e;
            @(negedge clk);
            if (out_valid && out_ready && !redirect_valid && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_pc=0x%08h required=none", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_ins", out_instruction, e.ins);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_addr", mem_address, BASE);
        chk("rst_ins", out_instruction, 32'd0);
        chk("rst_pc", out_pc, 32'd0);

        // Streaming, one instruction per cycle from the first cycle
        reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_item(k);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", out_pc, BASE + 32'(4 * k));
            chk("stream_ins", out_instruction, 32'(11 * (k + 1)));
        end
        step();
        reset = 1'b1; out_ready = 1'b0;
        step(); step();

        // Backpressure stall then release
        reset = 1'b0;
        repeat (5) step();
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc", out_pc, BASE);
        chk("stall_addr", mem_address, BASE + 32'h8);
        expect_item(0); expect_item(1); expect_item(2);
        out_ready = 1'b1;
        step(); chk("drain_pc1", out_pc, BASE + 32'h4);
        step(); chk("drain_pc2", out_pc, BASE + 32'h8);
        step();
        // Redirect while the buffer is full
        chk("full_pc", out_pc, BASE + 32'hC);
        redirect_valid = 1'b1; redirect_pc = BASE + 32'h40;
        step();
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", mem_address, BASE + 32'h40);
        redirect_valid = 1'b0;
        expect_item(16);
        step();
        chk("redir_pc", out_pc, BASE + 32'h40);
        chk("redir_ins", out_instruction, 32'd187);
        step();
        reset = 1'b1; out_ready = 1'b0;
        step(); step();

        // Run off the end of program memory
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE + 32'h74; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        expect_item(29); expect_item(30); expect_item(31);
        chk("end_addr", mem_address, BASE + 32'h74);
        step(); chk("end_pc29", out_pc, BASE + 32'h74);
        step();
        step();
        chk("end_pc31", out_pc, BASE + 32'h7C);
        chk("end_nofault", 32'(fault), 32'd0);
        chk("end_addr80", mem_address, BASE + 32'h80);
        step();
        chk("end_fault", 32'(fault), 32'd1);
        chk("end_valid0", 32'(out_valid), 32'd0);
        step();
        chk("end_fault_hold", 32'(fault), 32'd1);
        chk("end_addr_hold", mem_address, BASE + 32'h80);
        chk("end_nopush", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = BASE;
        step();
        chk("clr_fault", 32'(fault), 32'd0);
        redirect_valid = 1'b0;
        expect_item(0);
        step();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_pc", out_pc, BASE);
        step();
        reset = 1'b1; out_ready = 1'b0;
        step(); step();

        // Buffer keeps draining while faulted
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE + 32'h78;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        chk("fdrain_fault", 32'(fault), 32'd1);
        chk("fdrain_valid", 32'(out_valid), 32'd1);
        chk("fdrain_pc", out_pc, BASE + 32'h78);
        chk("fdrain_addr", mem_address, BASE + 32'h80);
        expect_item(30); expect_item(31);
        out_ready = 1'b1;
        step();
        chk("fdrain_pc2", out_pc, BASE + 32'h7C);
        chk("fdrain_fault2", 32'(fault), 32'd1);
        step();
        chk("fdrain_empty", 32'(out_valid), 32'd0);
        chk("fdrain_fault3", 32'(fault), 32'd1);
        reset = 1'b1; out_ready = 1'b0;
        step(); step();
        chk("fdrain_rst", 32'(fault), 32'd0);

        // Misaligned redirect, then reset clears the fault
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE + 32'h2; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr", mem_address, BASE + 32'h2);
        chk("mis_nofault", 32'(fault), 32'd0);
        step();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        step();
        chk("mis_rst_fault", 32'(fault), 32'd0);
        chk("mis_rst_addr", mem_address, BASE);
        chk("mis_rst_valid", 32'(out_valid), 32'd0);

        // Just below the program space
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE - 32'h4;
        step();
        redirect_valid = 1'b0;
        step();
        chk("below_fault", 32'(fault), 32'd1);
        reset = 1'b1; out_ready = 1'b0;
        step(); step();

        // Reset beats a same-cycle redirect
        reset = 1'b0;
        step(); step();
        chk("rr_full", 32'(out_valid), 32'd1);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = BASE + 32'h40;
        step();
        chk("rr_addr", mem_address, BASE);
        chk("rr_valid", 32'(out_valid), 32'd0);
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        expect_item(0);
        step();
        chk("rr_first_valid", 32'(out_valid), 32'd1);
        chk("rr_first_pc", out_pc, BASE);
        step();
        out_ready = 1'b0;
        step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0040_0000, first fetch address and base of program memory space.
REQ-002 Parameter: MEMORY_DEPTH, default 32, number of 32-bit words in program memory.
REQ-003 Parameter: DATA_WIDTH, default 32, address/instruction width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_address  output  32  byte address to program memory; combinational copy of pc register.
REQ-007 mem_instruction  input  32  word returned combinationally by program memory for mem_address.
REQ-008 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse or held.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 out_valid  output  1  fetch buffer head holds valid instruction.
REQ-011 out_ready  input  1  decode accepts head this cycle.
REQ-012 out_instruction  output  32  head instruction word.
REQ-013 out_pc  output  32  byte address of head instruction.
REQ-014 fault  output  1  fetch halted on illegal pc.

Function
REQ-015 Internal state: pc register (32 b), 2-entry FIFO of {pc, instruction}, count 0..2, FSM {RUN, FAULT}.
REQ-016 legal(pc) = pc[1:0]==0 AND pc >= RESET_PC AND pc < RESET_PC + 4*MEMORY_DEPTH; compare at 33-bit width, no wrap.
REQ-017 pop = out_valid AND out_ready; pop removes head at the clock edge.
REQ-018 fetch = state==RUN AND !redirect_valid AND legal(pc) AND (count<2 OR pop).
REQ-019 On fetch: push {pc, mem_instruction} to FIFO tail; pc <= pc+4.
REQ-020 Simultaneous push and pop with count==2: count stays 2, order preserved, no loss.
REQ-021 Fetch-to-out_valid latency: 1 cycle (instruction visible on out_* the cycle after its address is on mem_address).
REQ-022 out_valid = count!=0; out_instruction/out_pc from FIFO head; stable while out_valid && !out_ready.
REQ-023 Count==2 and no pop: no fetch, pc holds (backpressure stall).
REQ-024 redirect_valid=1: FIFO flushed (count<=0), pc <= redirect_pc, no fetch, state <= RUN; pop in same cycle is ignored (head discarded by flush).
REQ-025 Redirect has priority over fetch, pop-driven refill and fault entry in the same cycle.
REQ-026 RUN and !legal(pc) and !redirect_valid: state <= FAULT; pc holds; no push.
REQ-027 FAULT: fault=1, no fetches; FIFO continues to drain via pop; exit only via redirect (to RUN) or reset.
REQ-028 fault is registered: asserted from the cycle after the illegal pc is first presented.
REQ-029 Illegal redirect_pc accepted into pc; fault follows per REQ-026 next cycle.

Reset
REQ-030 reset=1 at clock edge: pc<=RESET_PC, count<=0, state<=RUN; reset dominates redirect and pop.
REQ-031 Output values during/after reset: out_valid=0, fault=0, mem_address=RESET_PC, out_instruction=0, out_pc=0 while count==0.
REQ-032 reset asserted mid-operation discards all buffered instructions; first fetch in first cycle with reset=0.

Verification
REQ-033 Reset release, out_ready=1, ROM words 0..3 = 11,22,33,44 -> out_pc 0x0040_0000,_0004,_0008,_000C on consecutive cycles from cycle 1, out_instruction matches, one per cycle.
REQ-034 out_ready=0 for 5 cycles after reset -> count saturates 2, mem_address holds 0x0040_0008, out_pc stays 0x0040_0000; release -> _0000,_0004,_0008 in order, no gaps, no duplicates.
REQ-035 Redirect to 0x0040_0040 while count==2 and out_ready=1 -> next cycle out_valid=0, mem_address=0x0040_0040; following cycle out_pc=0x0040_0040.
REQ-036 Sequential run to 0x0040_0080 (MEMORY_DEPTH=32) -> fault=1 next cycle, last out_pc 0x0040_007C, no further pushes; redirect to 0x0040_0000 clears fault, fetch resumes.
REQ-037 Redirect to 0x0040_0002 -> fault=1 one cycle later, out_valid=0; reset asserted -> fault=0, mem_address=0x0040_0000.
REQ-038 Redirect and reset in same cycle -> pc=0x0040_0000 (reset wins), count=0.
